// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner. It drives the columns one at a time and
// samples the rows through a two-flop synchroniser. A press must stay
// stable for DEBOUNCE_TICKS scan ticks before it is accepted, and a
// release must stay stable for the same number of ticks before scanning
// resumes. Each accepted press gives one registered key event.
module keypad_scanner #(
    parameter int TICK_DIV       = 100_000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_TICKS - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]    row_meta_q, row_meta_d;
    logic [3:0]    row_s_q, row_s_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [3:0]    col_n_q, col_n_d;
    logic [3:0]    row_lat_q, row_lat_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;
    logic          tick;

    // The row with the lowest index that is pulled low selects the key.
    // The rows are active-low, so a 0 bit means a pressed row.
    function automatic logic [3:0] key_map(input logic [3:0] rows_n,
                                           input logic [1:0] col);
        logic [1:0] r;
        if (!rows_n[0])      r = 2'd0;
        else if (!rows_n[1]) r = 2'd1;
        else if (!rows_n[2]) r = 2'd2;
        else                 r = 2'd3;
        case ({r, col})
            4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;
            4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;
            4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;
            4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
            4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;
            4'hE: key_map = 4'hF;  default: key_map = 4'hD;
        endcase
    endfunction

    // Scan-rate divider and the row synchroniser. The tick is high for one
    // clk at the end of each divider period.
    always_comb begin
        tick       = (tick_cnt_q == TICK_MAX);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        row_meta_d = row_n;
        row_s_d    = row_meta_q;
    end

    // Scan/debounce/hold next-state logic. Nothing advances except on a tick.
    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_lat_d   = row_lat_q;
        deb_cnt_d   = deb_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (row_s_q == 4'b1111) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        row_lat_d = row_s_q;
                        deb_cnt_d = '0;
                        state_d   = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (row_s_q != row_lat_q) begin
                        state_d = SCAN;
                    end else if (deb_cnt_q == DEB_MAX) begin
                        key_code_d  = key_map(row_lat_q, col_idx_q);
                        key_valid_d = 1'b1;
                        deb_cnt_d   = '0;
                        state_d     = HOLD;
                    end else begin
                        deb_cnt_d = deb_cnt_q + DW'(1);
                    end
                end
                HOLD: begin
                    // A change in the row pattern while a key is held only
                    // restarts the release count. It never starts a new event.
                    if (row_s_q != 4'b1111) begin
                        deb_cnt_d = '0;
                    end else if (deb_cnt_q == DEB_MAX) begin
                        deb_cnt_d = '0;
                        col_idx_d = col_idx_q + 2'd1;
                        state_d   = SCAN;
                    end else begin
                        deb_cnt_d = deb_cnt_q + DW'(1);
                    end
                end
                default: state_d = SCAN;
            endcase
        end
        col_n_d = ~(4'b0001 << col_idx_d);
    end

    // All state registers. Reset has priority over every other action.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SCAN;
            tick_cnt_q  <= '0;
            row_meta_q  <= 4'b1111;
            row_s_q     <= 4'b1111;
            col_idx_q   <= 2'd0;
            col_n_q     <= 4'b1110;
            row_lat_q   <= 4'b1111;
            deb_cnt_q   <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            row_meta_q  <= row_meta_d;
            row_s_q     <= row_s_d;
            col_idx_q   <= col_idx_d;
            col_n_q     <= col_n_d;
            row_lat_q   <= row_lat_d;
            deb_cnt_q   <= deb_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign col_n     = col_n_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = (state_q == HOLD);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner. It contains a keypad matrix model, a cycle-level
// reference model of the scan rules, a per-cycle compare, directed scenarios
// with literal expectations, and a randomized press/bounce/reset phase.
module tb_keypad_scanner;

    localparam int TD = 4;
    localparam int DT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed = '0;   // bit r*4+c: key at row r, col c is down

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    keypad_scanner #(.TICK_DIV(TD), .DEBOUNCE_TICKS(DT)) dut (
        .clk(clk), .reset(reset), .row_n(row_n), .col_n(col_n),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a row is pulled low when a pressed key sits on a driven column.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && (col_n[c] === 1'b0)) row_n[r] = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. It keeps the synchroniser as two history slots and
    // the scan mode as a small integer.
    string keytab [4] = '{"123A", "456B", "789C", "E0FD"};
    localparam int M_SCAN = 0, M_DEB = 1, M_HOLD = 2;
    logic [3:0] m_s1, m_s2, m_lat, m_code;
    int  m_tick, m_mode, m_col, m_deb;
    bit  m_valid, m_ready = 0;

    function automatic logic [3:0] key_of(input logic [3:0] rows, input int col);
        int  r = 0;
        byte ch;
        while (r < 3 && rows[r]) r++;
        ch = keytab[r].getc(col);
        return (ch >= 8'd65) ? 4'(ch - 8'd55) : 4'(ch - 8'd48);
    endfunction

    initial forever begin
        logic [3:0] rs;
        bit t;
        @(posedge clk);
        if (reset) begin
            m_s1 = 4'hF; m_s2 = 4'hF; m_lat = 4'hF; m_code = 4'h0;
            m_tick = 0; m_mode = M_SCAN; m_col = 0; m_deb = 0;
            m_valid = 0; m_ready = 1;
        end else begin
            rs = m_s2;
            t = (m_tick == TD - 1);
            m_tick = (m_tick + 1) % TD;
            m_s2 = m_s1;
            m_s1 = row_n;
            m_valid = 0;
            if (t) begin
                if (m_mode == M_SCAN) begin
                    if (rs == 4'hF) m_col = (m_col + 1) % 4;
                    else begin m_lat = rs; m_deb = 0; m_mode = M_DEB; end
                end else if (m_mode == M_DEB) begin
                    if (rs != m_lat) m_mode = M_SCAN;
                    else if (m_deb == DT - 1) begin
                        m_code = key_of(m_lat, m_col); m_valid = 1; m_deb = 0; m_mode = M_HOLD;
                    end else m_deb++;
                end else begin
                    if (rs != 4'hF) m_deb = 0;
                    else if (m_deb == DT - 1) begin
                        m_mode = M_SCAN; m_col = (m_col + 1) % 4; m_deb = 0;
                    end else m_deb++;
                end
            end
        end
    end

    // Per-cycle compare against the model, sampled on the falling edge.
    initial forever begin
        logic [3:0] exp_col;
        @(negedge clk);
        if (m_ready) begin
            exp_col = ~(4'b0001 << m_col);
            chk("col_n", col_n, exp_col);
            chk("key_code", key_code, m_code);
            chk("key_valid", key_valid, m_valid);
            chk("key_held", key_held, m_mode == M_HOLD);
            if (key_valid === 1'b1) pulses++;
        end
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_held(input logic lvl, input int bound, input string name);
        bit found = 0;
        for (int i = 0; i < bound; i++) begin
            if (key_held === lvl) begin found = 1; break; end
            clks(1);
        end
        chk(name, found, 1);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        clks(1);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_seq [4];
        int p0, r, c, r2, c2, kind, n;
        bit got;
        exp_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

        // 1: reset state, then free scanning with no keys
        clks(2);
        reset = 1'b0;
        chk("rst_col_n", col_n, 4'b1110);
        chk("rst_key_code", key_code, 4'h0);
        chk("rst_key_valid", key_valid, 1'b0);
        chk("rst_key_held", key_held, 1'b0);
        for (int i = 0; i < 4; i++) begin
            clks(4);
            chk("scan_seq", col_n, exp_seq[i]);
        end

        // 2: clean press of (r1,c1)
        p0 = pulses;
        pressed[1*4+1] = 1'b1;
        clks(40);
        chk("t2_held_during", key_held, 1'b1);
        chk("t2_col_held", col_n, 4'b1101);
        pressed = '0;
        wait_held(1'b0, 100, "t2_release_timeout");
        chk("t2_col_after", col_n, 4'b1011);
        chk("t2_pulses", pulses - p0, 1);
        chk("t2_code", key_code, 4'h5);
        chk("t2_model_code", m_code, 4'h5);

        // 3: (r3,c0) then (r3,c3)
        p0 = pulses;
        pressed[3*4+0] = 1'b1;
        wait_held(1'b1, 200, "t3a_press_timeout");
        chk("t3a_code", key_code, 4'hE);
        clks(10);
        pressed = '0;
        wait_held(1'b0, 200, "t3a_release_timeout");
        pressed[3*4+3] = 1'b1;
        wait_held(1'b1, 200, "t3b_press_timeout");
        clks(10);
        pressed = '0;
        wait_held(1'b0, 200, "t3b_release_timeout");
        clks(20);
        chk("t3_code_holds", key_code, 4'hD);
        chk("t3_pulses", pulses - p0, 2);

        // 4: bouncing (r0,c2), toggled every tick
        p0 = pulses;
        for (int i = 0; i < 5; i++) begin
            pressed[0*4+2] = ~pressed[0*4+2];
            clks(4);
        end
        pressed = '0;
        clks(20);
        chk("t4_no_pulse", pulses - p0, 0);
        chk("t4_not_held", key_held, 1'b0);
        begin
            logic [3:0] c0 = col_n;
            got = 0;
            for (int i = 0; i < 8; i++) begin
                clks(1);
                if (col_n !== c0) got = 1;
            end
            chk("t4_scan_resumes", got, 1);
        end

        // 5: hold (r2,c0) and press (r0,c0) during the hold
        p0 = pulses;
        pressed[2*4+0] = 1'b1;
        wait_held(1'b1, 200, "t5_press_timeout");
        pressed[0*4+0] = 1'b1;
        clks(100);
        chk("t5_pulses", pulses - p0, 1);
        chk("t5_code", key_code, 4'h7);
        pressed = '0;
        wait_held(1'b0, 200, "t5_release_timeout");

        // 6: reset in the middle of a hold; the key is still pressed and is detected again
        pressed[2*4+0] = 1'b1;
        wait_held(1'b1, 200, "t6_press_timeout");
        pulse_reset();
        chk("t6_col_n", col_n, 4'b1110);
        chk("t6_held", key_held, 1'b0);
        chk("t6_code", key_code, 4'h0);
        p0 = pulses;
        got = 0;
        for (int i = 0; i < 100; i++) begin
            clks(1);
            if (pulses > p0) begin got = 1; break; end
        end
        chk("t6_redetect", got, 1);
        chk("t6_code_after", key_code, 4'h7);
        clks(30);
        chk("t6_single_pulse", pulses - p0, 1);
        pressed = '0;
        wait_held(1'b0, 200, "t6_release_timeout");

        // Randomized phase: clean presses, bounce, overlapping keys, resets
        for (int it = 0; it < 150; it++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            r2 = $urandom_range(0, 3);
            c2 = $urandom_range(0, 3);
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    pressed[r*4+c] = 1'b1;
                    clks($urandom_range(10, 70));
                    pressed = '0;
                end
                1: begin
                    n = $urandom_range(2, 8);
                    for (int k = 0; k < n; k++) begin
                        pressed[r*4+c] = ~pressed[r*4+c];
                        clks($urandom_range(1, 6));
                    end
                    pressed = '0;
                end
                2: begin
                    pressed[r*4+c] = 1'b1;
                    clks($urandom_range(5, 40));
                    pressed[r2*4+c2] = 1'b1;
                    clks($urandom_range(5, 40));
                    pressed[r*4+c] = 1'b0;
                    clks($urandom_range(0, 20));
                    pressed = '0;
                end
                default: begin
                    pressed[r*4+c] = 1'b1;
                    clks($urandom_range(1, 30));
                    if ($urandom_range(0, 2) == 0) pulse_reset();
                    clks($urandom_range(0, 10));
                    pressed = '0;
                end
            endcase
            clks($urandom_range(0, 40));
        end
        pressed = '0;
        clks(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the columns of a 4x4 matrix keypad and reads its rows. Emits one debounced, registered key event per physical press.
- Contains its own scan-rate tick divider, so one fast system clock runs the whole block.
- Output feeds the display/digit-history logic. It is the consumer side of the slow-tick timing our clock divider provides elsewhere.

Parameters:
- TICK_DIV, 100_000, clk cycles per scan tick (tick is one clk wide, every TICK_DIV cycles); must be >= 2.
- DEBOUNCE_TICKS, 4, consecutive stable ticks required to accept a press and to accept a release; must be >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- row_n  input  4  keypad rows, active-low, externally pulled up; asynchronous to clk.
- col_n  output  4  column drive, one-hot active-low.
- key_code  output  4  hex code of the last accepted key; holds its value between events.
- key_valid  output  1  one-clk pulse when a new key is accepted.
- key_held  output  1  high while in HOLD (accepted key not yet released).

Behaviour:
- Reset (clk edge with reset=1):
  - col_n=4'b1110, col_idx=0, key_code=4'h0, key_valid=0, key_held=0.
  - state=SCAN, tick counter=0, debounce counter=0.
  - Both row synchroniser stages=4'b1111.
- Reset has priority over all other activity, including mid-DEBOUNCE and mid-HOLD.
- Synchroniser: row_n passes through 2 flops to give row_s. All decisions use row_s only.
- Tick:
  - tick_cnt counts 0..TICK_DIV-1 and wraps.
  - tick=1 for the single cycle where tick_cnt==TICK_DIV-1.
  - The FSM changes state, col_idx, or counters only on tick cycles.
- col_n = ~(4'b0001 << col_idx), registered, updated together with col_idx.
- SCAN:
  - On tick with row_s==4'b1111: col_idx <= col_idx+1 (3 wraps to 0).
  - On tick with row_s!=4'b1111: latch row_s into row_lat; deb_cnt<=0; go DEBOUNCE; col_idx unchanged.
- DEBOUNCE (column held):
  - On tick with row_s!=row_lat: go SCAN; col_idx unchanged; no event.
  - On tick with row_s==row_lat and deb_cnt==DEBOUNCE_TICKS-1: key_code<=map(row_lat,col_idx); key_valid<=1 for exactly one clk; deb_cnt<=0; go HOLD.
  - Otherwise: deb_cnt++.
- HOLD (column held, key_held=1):
  - On tick with row_s==4'b1111: deb_cnt++.
  - When deb_cnt==DEBOUNCE_TICKS-1 at such a tick: go SCAN and col_idx <= col_idx+1.
  - On tick with any row low: deb_cnt<=0. No new event, even if the row pattern changes.
- Multiple rows low: the lowest-index low row of row_lat selects the key.
- Key map (row r, col c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- Latency: rows low on the active column → DEBOUNCE entry at the first tick after 2 sync clks. key_valid follows exactly DEBOUNCE_TICKS ticks later.
- key_valid never asserts on reset release. It never asserts twice for one continuous press.

Test Plan:
Bench uses TICK_DIV=4 and DEBOUNCE_TICKS=3. Keypad model: row_n[r]=0 iff key(r,c) pressed and col_n[c]=0.
1. Reset, no keys → col_n cycles 1110→1101→1011→0111→1110, changing every 4 clks; key_valid=0, key_code=0, key_held=0.
2. Press (r1,c1) cleanly for 40 clks → single key_valid pulse with key_code=4'h5, 3 ticks after detection. col_n stays 1101 and key_held=1 while pressed. After release, 3 ticks later col_n=1011 and key_held=0.
3. Press (r3,c0), then separately (r3,c3) → two pulses, key_code=4'hE then 4'hD. key_code holds 4'hD afterwards.
4. Bounce: (r0,c2) toggles every tick for 5 ticks, then released → no key_valid; FSM returns to SCAN, then scanning resumes.
5. Hold (r2,c0) for 100 clks, pressing (r0,c0) during HOLD → exactly one pulse with key_code=4'h7. No pulse for the second key.
6. Assert reset for 1 clk mid-HOLD → next cycle col_n=1110, key_held=0, key_code=0. A still-pressed key on col0 is re-detected and produces one new pulse.
